// File: rtl/cond_branch_unit.sv
// Branch resolution at EX/MEM: holds NZCV, resolves B/CBZ/B.cond with same-cycle flag forwarding,
// issues flush/redirect and masks wrong-path flag writes. Optional BRANCH_STATS_EN adds branch counters.
module cond_branch_unit #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_setflags,
    input  logic [3:0]  ex_nzcv,
    input  logic        br_valid,
    input  logic [1:0]  br_type,
    input  logic [3:0]  br_cond,
    input  logic        br_reg_zero,
    input  logic [63:0] br_target,
    output logic [3:0]  flags_q,
    output logic        br_done,
    output logic        br_taken,
    output logic        flush,
    output logic [63:0] redirect_pc
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] stat_taken,
    output logic [31:0] stat_not_taken
`endif
);

    localparam int CW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic {RUN, SQUASH} state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;

    logic            flag_wr;
    logic [3:0]      eff;
    logic            n_f, z_f, c_f, v_f;
    logic            cond_ok;
    logic            taken_next;
    logic            resolve;

    always_comb begin
        flag_wr = (state_reg == RUN) && ex_valid && ex_setflags;
        // Forward a same-cycle producer so the branch sees the flags it commits with.
        eff = flag_wr ? ex_nzcv : flags_q;
        {n_f, z_f, c_f, v_f} = eff;

        cond_ok = 1'b0;
        case (br_cond)
            4'b0000: cond_ok = z_f;
            4'b0001: cond_ok = !z_f;
            4'b0010: cond_ok = c_f;
            4'b0011: cond_ok = !c_f;
            4'b0100: cond_ok = n_f;
            4'b0101: cond_ok = !n_f;
            4'b0110: cond_ok = v_f;
            4'b0111: cond_ok = !v_f;
            4'b1000: cond_ok = c_f && !z_f;
            4'b1001: cond_ok = !(c_f && !z_f);
            4'b1010: cond_ok = (n_f == v_f);
            4'b1011: cond_ok = (n_f != v_f);
            4'b1100: cond_ok = !z_f && (n_f == v_f);
            4'b1101: cond_ok = !(!z_f && (n_f == v_f));
            default: cond_ok = 1'b1;
        endcase

        taken_next = 1'b0;
        case (br_type)
            2'b01:   taken_next = 1'b1;
            2'b10:   taken_next = br_reg_zero;
            2'b11:   taken_next = cond_ok;
            default: taken_next = 1'b0;
        endcase

        resolve = (state_reg == RUN) && br_valid && (br_type != 2'b00);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= RUN;
            cnt_reg     <= '0;
            flags_q     <= '0;
            br_done     <= 1'b0;
            br_taken    <= 1'b0;
            flush       <= 1'b0;
            redirect_pc <= '0;
        end else begin
            br_done  <= resolve;
            br_taken <= resolve && taken_next;
            flush    <= resolve && taken_next;
            if (resolve && taken_next)
                redirect_pc <= br_target;
            if (flag_wr)
                flags_q <= ex_nzcv;

            if (state_reg == RUN) begin
                if (resolve && taken_next) begin
                    state_reg <= SQUASH;
                    cnt_reg   <= FLUSH_LOAD;
                end
            end else begin
                // Last squash cycle: reopen for flags and branches next cycle.
                if (cnt_reg == CNT_ONE) begin
                    state_reg <= RUN;
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg - CNT_ONE;
                end
            end
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_taken     <= '0;
            stat_not_taken <= '0;
        end else if (br_done) begin
            if (br_taken && (stat_taken != 32'hFFFF_FFFF))
                stat_taken <= stat_taken + 32'd1;
            if (!br_taken && (stat_not_taken != 32'hFFFF_FFFF))
                stat_not_taken <= stat_not_taken + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cond_branch_unit.sv
// Bench for cond_branch_unit: directed scenarios plus random traffic against a cycle-level reference model.
module tb_cond_branch_unit;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_setflags, br_valid, br_reg_zero;
    logic [3:0]  ex_nzcv, br_cond;
    logic [1:0]  br_type;
    logic [63:0] br_target;
    logic [3:0]  flags_q;
    logic        br_done, br_taken, flush;
    logic [63:0] redirect_pc;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_taken, stat_not_taken;
    int          m_st, m_snt;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [3:0]  m_flags;
    int          m_sq;
    logic        m_done, m_taken, m_flush;
    logic [63:0] m_pc;

    cond_branch_unit #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_setflags(ex_setflags), .ex_nzcv(ex_nzcv),
        .br_valid(br_valid), .br_type(br_type), .br_cond(br_cond),
        .br_reg_zero(br_reg_zero), .br_target(br_target),
        .flags_q(flags_q), .br_done(br_done), .br_taken(br_taken),
        .flush(flush), .redirect_pc(redirect_pc)
`ifdef BRANCH_STATS_EN
        , .stat_taken(stat_taken), .stat_not_taken(stat_not_taken)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ARM condition: pairs share a base test, odd codes invert it; 111x is always.
    function automatic logic cond_holds(input logic [3:0] cc, input logic [3:0] f);
        logic r;
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cc[3:1])
            3'd0: r = z;
            3'd1: r = c;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = c && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: return 1'b1;
        endcase
        return cc[0] ? !r : r;
    endfunction

    task automatic idle_inputs();
        ex_valid = 0; ex_setflags = 0; ex_nzcv = 0;
        br_valid = 0; br_type = 0; br_cond = 0; br_reg_zero = 0; br_target = 0;
    endtask

    task automatic model_reset();
        m_flags = 0; m_sq = 0; m_done = 0; m_taken = 0; m_flush = 0; m_pc = 0;
`ifdef BRANCH_STATS_EN
        m_st = 0; m_snt = 0;
`endif
    endtask

    // Advance one clock with current inputs, update the model, compare all outputs.
    task automatic step();
        logic run, wr, dec, tk;
        logic [3:0] eff;
        run = (m_sq == 0);
        wr  = run && ex_valid && ex_setflags;
        eff = wr ? ex_nzcv : m_flags;
        dec = run && br_valid && (br_type != 2'b00);
        tk  = (br_type == 2'b01) || (br_type == 2'b10 && br_reg_zero) ||
              (br_type == 2'b11 && cond_holds(br_cond, eff));
        @(posedge clk);
        #1;
`ifdef BRANCH_STATS_EN
        if (m_done && m_taken) m_st++;
        if (m_done && !m_taken) m_snt++;
`endif
        m_done  = dec;
        m_taken = dec && tk;
        m_flush = dec && tk;
        if (m_flush) m_pc = br_target;
        if (wr) m_flags = ex_nzcv;
        if (dec && tk) m_sq = FC;
        else if (m_sq > 0) m_sq--;
        check("flags_q", 64'(flags_q), 64'(m_flags));
        check("br_done", 64'(br_done), 64'(m_done));
        check("br_taken", 64'(br_taken), 64'(m_taken));
        check("flush", 64'(flush), 64'(m_flush));
        check("redirect_pc", redirect_pc, m_pc);
`ifdef BRANCH_STATS_EN
        check("stat_taken", 64'(stat_taken), 64'(m_st));
        check("stat_not_taken", 64'(stat_not_taken), 64'(m_snt));
`endif
        $display("cyc ex=%0d sf=%0d nzcv=%b br=%0d ty=%0d cc=%h -> flags=%b done=%0d tk=%0d fl=%0d pc=%h",
                 ex_valid, ex_setflags, ex_nzcv, br_valid, br_type, br_cond,
                 flags_q, br_done, br_taken, flush, redirect_pc);
        idle_inputs();
    endtask

    task automatic do_reset();
        reset = 1;
        #1;
        model_reset();
        check("rst_flags", 64'(flags_q), 64'h0);
        check("rst_done", 64'(br_done), 64'h0);
        check("rst_flush", 64'(flush), 64'h0);
        check("rst_pc", redirect_pc, 64'h0);
        #2 reset = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 0;
        #2;
        do_reset();
        step();

        // Reset in the middle of a squash
        br_valid = 1; br_type = 2'b01; br_target = 64'h1234;
        step();
        check("pre_rst_flush", 64'(flush), 64'h1);
        do_reset();
        br_valid = 1; br_type = 2'b01; br_target = 64'h88;
        step();
        check("post_rst_branch", 64'(flush), 64'h1);
        repeat (FC) step();

        // SUBS Z, then B.EQ next cycle
        ex_valid = 1; ex_setflags = 1; ex_nzcv = 4'b0100;
        step();
        br_valid = 1; br_type = 2'b11; br_cond = 4'b0000; br_target = 64'h400;
        step();
        check("eq_taken", 64'(br_taken), 64'h1);
        check("eq_pc", redirect_pc, 64'h400);

        // Squash window masks flag writes, then reopens
        ex_valid = 1; ex_setflags = 1; ex_nzcv = 4'b0001;
        step();
        ex_valid = 1; ex_setflags = 1; ex_nzcv = 4'b0001;
        step();
        check("sq_mask", 64'(flags_q), 64'(4'b0100));
        ex_valid = 1; ex_setflags = 1; ex_nzcv = 4'b0001;
        step();
        check("sq_open", 64'(flags_q), 64'(4'b0001));

        // Forwarded same-cycle flags for B.LT
        ex_valid = 1; ex_setflags = 1; ex_nzcv = 4'b0000;
        step();
        ex_valid = 1; ex_setflags = 1; ex_nzcv = 4'b1000;
        br_valid = 1; br_type = 2'b11; br_cond = 4'b1011; br_target = 64'hABC0;
        step();
        check("lt_fwd_taken", 64'(br_taken), 64'h1);
        check("lt_fwd_flags", 64'(flags_q), 64'(4'b1000));
        repeat (FC) step();

        // CBZ not taken, ADD without setflags
        br_valid = 1; br_type = 2'b10; br_reg_zero = 0; br_target = 64'hDEAD;
        ex_valid = 1; ex_setflags = 0; ex_nzcv = 4'b1111;
        step();
        check("cbz_nt_done", 64'(br_done), 64'h1);
        check("cbz_nt_flush", 64'(flush), 64'h0);
        check("add_noflags", 64'(flags_q), 64'(4'b1000));
        br_valid = 1; br_type = 2'b00;
        step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            ex_valid    = ($urandom_range(0, 3) != 0);
            ex_setflags = $urandom_range(0, 1);
            ex_nzcv     = 4'($urandom);
            br_valid    = ($urandom_range(0, 2) == 0);
            br_type     = 2'($urandom);
            br_cond     = 4'($urandom);
            br_reg_zero = $urandom_range(0, 1);
            br_target   = {$urandom, $urandom};
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
